// File: rtl/edge_density_pkg.sv
// Shared types and default geometry for the edge-density grid tracker family.
//   ed_state_t : smoothing/decision FSM states
//   ED_*       : default frame/grid geometry and derived widths
package edge_density_pkg;

  typedef enum logic [1:0] {IDLE, SMOOTH, SCAN, DECIDE} ed_state_t;

  localparam int unsigned ED_WIDTH  = 640;
  localparam int unsigned ED_HEIGHT = 480;
  localparam int unsigned ED_COLS   = 18;
  localparam int unsigned ED_ROWS   = 3;
  localparam int unsigned ED_N      = ED_COLS * ED_ROWS;
  localparam int unsigned ED_CELL_W = $clog2(ED_N);
  localparam int unsigned ED_COL_W  = $clog2(ED_COLS);
  localparam int unsigned ED_ROW_W  = $clog2(ED_ROWS);

endpackage

// File: rtl/edge_cell_mapper.sv
// Combinational pixel-to-grid-cell mapper.
//   x_i/y_i   : pixel column/row
//   col_o     : x*COLS/WIDTH clamped to COLS-1
//   row_o     : y*ROWS/HEIGHT clamped to ROWS-1
//   cell_o    : row*COLS + col
module edge_cell_mapper
  import edge_density_pkg::*;
#(
  parameter int unsigned WIDTH  = ED_WIDTH,
  parameter int unsigned HEIGHT = ED_HEIGHT,
  parameter int unsigned COLS   = ED_COLS,
  parameter int unsigned ROWS   = ED_ROWS,
  parameter int unsigned COL_W  = $clog2(COLS),
  parameter int unsigned ROW_W  = $clog2(ROWS),
  parameter int unsigned CELL_W = $clog2(COLS * ROWS)
) (
  input  logic [9:0]        x_i,
  input  logic [8:0]        y_i,
  output logic [COL_W-1:0]  col_o,
  output logic [ROW_W-1:0]  row_o,
  output logic [CELL_W-1:0] cell_o
);

  logic [31:0] col_raw;
  logic [31:0] row_raw;

  always_comb begin
    col_raw = (32'(x_i) * COLS) / WIDTH;
    if (col_raw > COLS - 1) col_raw = COLS - 1;
    row_raw = (32'(y_i) * ROWS) / HEIGHT;
    if (row_raw > ROWS - 1) row_raw = ROWS - 1;
    col_o  = COL_W'(col_raw);
    row_o  = ROW_W'(row_raw);
    cell_o = CELL_W'(row_raw * COLS + col_raw);
  end

endmodule

// File: rtl/edge_density_grid_tracker.sv
// Bins thresholded Sobel pixels into a COLS x ROWS grid, smooths per-cell
// counts once per frame (one cell per clock) and tracks the densest cell
// with hysteresis and an activation gate.
//   clk/reset        : clock, synchronous active-high reset
//   vga_ready        : pixel qualifier for x_count/y_count/filtered_video
//   section_leds     : one-hot column of tracked cell, 0 when no pattern
//   target_col/row   : tracked cell
//   pattern_detected : smoothed max >= ACT_THRESH at last decision
//   result_valid     : 1-clk pulse when the outputs above update
//   busy             : FSM not idle
//   overrun          : sticky, frame end seen while busy
module edge_density_grid_tracker
  import edge_density_pkg::*;
#(
  parameter int unsigned WIDTH        = ED_WIDTH,
  parameter int unsigned HEIGHT       = ED_HEIGHT,
  parameter int unsigned COLS         = ED_COLS,
  parameter int unsigned ROWS         = ED_ROWS,
  parameter int unsigned PIX_W        = 12,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned EDGE_THRESH  = 128,
  parameter int unsigned DECAY_SHIFT  = 4,
  parameter int unsigned SMOOTH_SHIFT = 2,
  parameter int unsigned HYST_SHIFT   = 3,
  parameter int unsigned ACT_THRESH   = 30
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     vga_ready,
  input  logic [PIX_W-1:0]         filtered_video,
  input  logic [9:0]               x_count,
  input  logic [8:0]               y_count,
  output logic [COLS-1:0]          section_leds,
  output logic [$clog2(COLS)-1:0]  target_col,
  output logic [$clog2(ROWS)-1:0]  target_row,
  output logic                     pattern_detected,
  output logic                     result_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int unsigned N      = COLS * ROWS;
  localparam int unsigned CELL_W = $clog2(N);
  localparam int unsigned COL_W  = $clog2(COLS);
  localparam int unsigned ROW_W  = $clog2(ROWS);
  localparam logic [CELL_W-1:0] LAST_IDX = CELL_W'(N - 1);

  ed_state_t state_q, state_d;
  logic [CELL_W-1:0] idx_q, idx_d;

  logic [CNT_W-1:0] count_q  [N];
  logic [CNT_W-1:0] count_d  [N];
  logic [CNT_W-1:0] shadow_q [N];
  logic [CNT_W-1:0] smooth_q [N];

  logic [CNT_W-1:0]  max_q;
  logic [CELL_W-1:0] max_idx_q;
  logic [CELL_W-1:0] cur_idx_q;
  logic [COLS-1:0]   leds_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic              pattern_q;
  logic              valid_q;
  logic              overrun_q;

  logic [COL_W-1:0]  map_col;
  logic [ROW_W-1:0]  map_row;
  logic [CELL_W-1:0] map_cell;

  edge_cell_mapper #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .COLS   (COLS),
    .ROWS   (ROWS),
    .COL_W  (COL_W),
    .ROW_W  (ROW_W),
    .CELL_W (CELL_W)
  ) u_mapper (
    .x_i    (x_count),
    .y_i    (y_count),
    .col_o  (map_col),
    .row_o  (map_row),
    .cell_o (map_cell)
  );

  logic is_edge, at_origin, frame_end;
  assign is_edge   = filtered_video > PIX_W'(EDGE_THRESH);
  assign at_origin = (x_count == '0) && (y_count == '0);
  assign frame_end = vga_ready && (x_count == 10'(WIDTH - 1)) && (y_count == 9'(HEIGHT - 1));

  // Next counts are also what the shadow captures, so the frame-end pixel's own edge lands in it.
  always_comb begin
    count_d = count_q;
    if (vga_ready) begin
      if (at_origin) begin
        for (int unsigned i = 0; i < N; i++) count_d[i] = '0;
        count_d[map_cell] = CNT_W'(is_edge);
      end else if (is_edge && (count_q[map_cell] != '1)) begin
        count_d[map_cell] = count_q[map_cell] + 1'b1;
      end
    end
  end

  logic [CNT_W-1:0] s_cur, sh_cur, s_next, cur_s;
  logic [CNT_W:0]   smooth_sum, hyst_thr;
  logic             take_max;
  logic [CELL_W-1:0] new_idx;
  logic [COL_W-1:0]  new_col;
  logic [ROW_W-1:0]  new_row;

  always_comb begin
    s_cur      = smooth_q[idx_q];
    sh_cur     = shadow_q[idx_q];
    smooth_sum = {1'b0, s_cur} - {1'b0, s_cur >> DECAY_SHIFT} + {1'b0, sh_cur >> SMOOTH_SHIFT};
    s_next     = smooth_sum[CNT_W] ? '1 : smooth_sum[CNT_W-1:0];

    cur_s    = smooth_q[cur_idx_q];
    hyst_thr = {1'b0, cur_s} + {1'b0, cur_s >> HYST_SHIFT};
    take_max = (max_idx_q == cur_idx_q) || ({1'b0, max_q} > hyst_thr);
    new_idx  = take_max ? max_idx_q : cur_idx_q;
    new_col  = COL_W'(32'(new_idx) % COLS);
    new_row  = ROW_W'(32'(new_idx) / COLS);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (frame_end) begin
          state_d = SMOOTH;
          idx_d   = '0;
        end
      end
      SMOOTH, SCAN: begin
        if (idx_q == LAST_IDX) begin
          state_d = (state_q == SMOOTH) ? SCAN : DECIDE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DECIDE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        count_q[i]  <= '0;
        shadow_q[i] <= '0;
        smooth_q[i] <= '0;
      end
      max_q     <= '0;
      max_idx_q <= '0;
      cur_idx_q <= '0;
      leds_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      pattern_q <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      valid_q <= 1'b0;
      if (frame_end) begin
        if (state_q == IDLE) shadow_q <= count_d;
        else                 overrun_q <= 1'b1;
      end
      unique case (state_q)
        SMOOTH: begin
          smooth_q[idx_q] <= s_next;
          max_q           <= '0;
          max_idx_q       <= '0;
        end
        SCAN: begin
          if (smooth_q[idx_q] > max_q) begin
            max_q     <= smooth_q[idx_q];
            max_idx_q <= idx_q;
          end
        end
        DECIDE: begin
          pattern_q <= (max_q >= CNT_W'(ACT_THRESH));
          if (max_q >= CNT_W'(ACT_THRESH)) begin
            cur_idx_q <= new_idx;
            col_q     <= new_col;
            row_q     <= new_row;
            leds_q    <= COLS'(1) << new_col;
          end else begin
            leds_q <= '0;
          end
          valid_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign section_leds     = leds_q;
  assign target_col       = col_q;
  assign target_row       = row_q;
  assign pattern_detected = pattern_q;
  assign result_valid     = valid_q;
  assign busy             = (state_q != IDLE);
  assign overrun          = overrun_q;

endmodule

// File: tb/tb_edge_density_grid_tracker.sv
module tb_edge_density_grid_tracker;

  localparam int N   = 54;
  localparam int LAT = 2 * N + 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        vga_ready;
  logic [11:0] filtered_video;
  logic [9:0]  x_count;
  logic [8:0]  y_count;

  logic [17:0] section_leds,  s_section_leds;
  logic [4:0]  target_col,    s_target_col;
  logic [1:0]  target_row,    s_target_row;
  logic        pattern_detected, s_pattern_detected;
  logic        result_valid,  s_result_valid;
  logic        busy,          s_busy;
  logic        overrun,       s_overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  edge_density_grid_tracker dut (
    .clk              (clk),
    .reset            (reset),
    .vga_ready        (vga_ready),
    .filtered_video   (filtered_video),
    .x_count          (x_count),
    .y_count          (y_count),
    .section_leds     (section_leds),
    .target_col       (target_col),
    .target_row       (target_row),
    .pattern_detected (pattern_detected),
    .result_valid     (result_valid),
    .busy             (busy),
    .overrun          (overrun)
  );

  // Narrow-count instance: lets count and smoothed saturation show up within a few frames.
  edge_density_grid_tracker #(.CNT_W(8)) dut_sat (
    .clk              (clk),
    .reset            (reset),
    .vga_ready        (vga_ready),
    .filtered_video   (filtered_video),
    .x_count          (x_count),
    .y_count          (y_count),
    .section_leds     (s_section_leds),
    .target_col       (s_target_col),
    .target_row       (s_target_row),
    .pattern_detected (s_pattern_detected),
    .result_valid     (s_result_valid),
    .busy             (s_busy),
    .overrun          (s_overrun)
  );

  task automatic do_reset();
    reset = 1'b1;
    vga_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic pixel(input int x, input int y, input int v);
    vga_ready      = 1'b1;
    x_count        = 10'(x);
    y_count        = 9'(y);
    filtered_video = 12'(v);
    @(posedge clk);
    #1;
    vga_ready      = 1'b0;
    filtered_video = '0;
  endtask

  task automatic burst(input int x, input int y, input int n, input int v);
    for (int i = 0; i < n; i++) pixel(x, y, v);
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    while (result_valid !== 1'b1 && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (section_leds !== 18'h0) begin $display("FAIL reset_leds got %h want 0", section_leds); errors++; end
    checks++; if (target_col !== 5'd0 || target_row !== 2'd0) begin $display("FAIL reset_target got %0d,%0d want 0,0", target_row, target_col); errors++; end
    checks++; if (pattern_detected !== 1'b0 || result_valid !== 1'b0) begin $display("FAIL reset_flags got pat=%b rv=%b want 0,0", pattern_detected, result_valid); errors++; end
    checks++; if (busy !== 1'b0 || overrun !== 1'b0) begin $display("FAIL reset_busy got busy=%b ovr=%b want 0,0", busy, overrun); errors++; end
  endtask

  task automatic test_single_hot();
    int lat;
    do_reset();
    pixel(0, 0, 0);
    burst(182, 170, 200, 200);
    burst(182, 170, 30, 128);
    pixel(639, 479, 0);
    checks++; if (busy !== 1'b1) begin $display("FAIL hot_busy got %b want 1", busy); errors++; end
    wait_result(lat);
    checks++; if (lat != LAT) begin $display("FAIL hot_latency got %0d want %0d", lat, LAT); errors++; end
    checks++; if (pattern_detected !== 1'b1) begin $display("FAIL hot_pattern got %b want 1", pattern_detected); errors++; end
    checks++; if (target_row !== 2'd1 || target_col !== 5'd5) begin $display("FAIL hot_target got %0d,%0d want 1,5", target_row, target_col); errors++; end
    checks++; if (section_leds !== 18'h00020) begin $display("FAIL hot_leds got %h want 00020", section_leds); errors++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL hot_idle got %b want 0", busy); errors++; end
  endtask

  task automatic test_reset_mid_scan();
    int seen = 0;
    pixel(0, 0, 0);
    burst(182, 170, 200, 200);
    pixel(639, 479, 0);
    repeat (60) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b1) begin $display("FAIL midscan_busy got %b want 1", busy); errors++; end
    do_reset();
    checks++; if (section_leds !== 18'h0 || target_col !== 5'd0 || target_row !== 2'd0 || pattern_detected !== 1'b0) begin
      $display("FAIL midscan_outputs got leds=%h col=%0d row=%0d pat=%b want 0", section_leds, target_col, target_row, pattern_detected); errors++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL midscan_idle got %b want 0", busy); errors++; end
    repeat (4 * N) begin
      @(posedge clk); #1;
      if (result_valid === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin $display("FAIL midscan_no_valid got %0d pulses want 0", seen); errors++; end
  endtask

  task automatic test_activation();
    int lat;
    do_reset();
    pixel(0, 0, 0);
    burst(182, 170, 100, 200);
    burst(182, 170, 30, 128);
    pixel(639, 479, 0);
    wait_result(lat);
    checks++; if (lat != LAT) begin $display("FAIL act1_latency got %0d want %0d", lat, LAT); errors++; end
    checks++; if (pattern_detected !== 1'b0 || section_leds !== 18'h0) begin $display("FAIL act1_gate got pat=%b leds=%h want 0,0", pattern_detected, section_leds); errors++; end
    checks++; if (target_row !== 2'd0 || target_col !== 5'd0) begin $display("FAIL act1_held got %0d,%0d want 0,0", target_row, target_col); errors++; end
    pixel(0, 0, 0);
    burst(182, 170, 100, 200);
    pixel(639, 479, 0);
    wait_result(lat);
    checks++; if (pattern_detected !== 1'b1 || section_leds !== 18'h00020) begin $display("FAIL act2_gate got pat=%b leds=%h want 1,00020", pattern_detected, section_leds); errors++; end
    checks++; if (target_row !== 2'd1 || target_col !== 5'd5) begin $display("FAIL act2_target got %0d,%0d want 1,5", target_row, target_col); errors++; end
  endtask

  task automatic test_clear();
    int lat;
    do_reset();
    pixel(0, 0, 0);
    burst(182, 170, 200, 200);
    pixel(639, 479, 0);
    wait_result(lat);
    pixel(0, 0, 0);
    burst(110, 10, 240, 200);
    pixel(639, 479, 0);
    wait_result(lat);
    checks++; if (lat != LAT) begin $display("FAIL clear_latency got %0d want %0d", lat, LAT); errors++; end
    checks++; if (target_row !== 2'd0 || target_col !== 5'd3 || section_leds !== 18'h00008) begin
      $display("FAIL clear_target got %0d,%0d leds=%h want 0,3 00008", target_row, target_col, section_leds); errors++; end
  endtask

  task automatic test_hysteresis();
    int lat;
    do_reset();
    pixel(0, 0, 0);
    burst(110, 10, 1600, 200);
    pixel(639, 479, 0);
    wait_result(lat);
    checks++; if (target_col !== 5'd3 || section_leds !== 18'h00008) begin $display("FAIL hyst_a got col=%0d leds=%h want 3 00008", target_col, section_leds); errors++; end
    pixel(0, 0, 0);
    burst(110, 10, 100, 200);
    burst(252, 10, 1760, 200);
    pixel(639, 479, 0);
    wait_result(lat);
    checks++; if (pattern_detected !== 1'b1 || target_col !== 5'd3 || section_leds !== 18'h00008) begin
      $display("FAIL hyst_hold got pat=%b col=%0d leds=%h want 1 3 00008", pattern_detected, target_col, section_leds); errors++; end
    pixel(0, 0, 0);
    burst(110, 10, 100, 200);
    burst(252, 10, 188, 200);
    pixel(639, 479, 0);
    wait_result(lat);
    checks++; if (target_row !== 2'd0 || target_col !== 5'd7 || section_leds !== 18'h00080) begin
      $display("FAIL hyst_switch got %0d,%0d leds=%h want 0,7 00080", target_row, target_col, section_leds); errors++; end
  endtask

  task automatic test_tie();
    int lat;
    do_reset();
    pixel(0, 0, 0);
    burst(110, 10, 160, 200);
    burst(252, 10, 160, 200);
    pixel(639, 479, 0);
    wait_result(lat);
    checks++; if (target_col !== 5'd3 || section_leds !== 18'h00008) begin $display("FAIL tie_lowest got col=%0d leds=%h want 3 00008", target_col, section_leds); errors++; end
  endtask

  task automatic test_frame_end_edge();
    int lat;
    do_reset();
    pixel(0, 0, 0);
    burst(638, 479, 119, 200);
    pixel(639, 479, 200);
    wait_result(lat);
    checks++; if (pattern_detected !== 1'b1) begin $display("FAIL fe_pattern got %b want 1", pattern_detected); errors++; end
    checks++; if (target_row !== 2'd2 || target_col !== 5'd17 || section_leds !== 18'h20000) begin
      $display("FAIL fe_target got %0d,%0d leds=%h want 2,17 20000", target_row, target_col, section_leds); errors++; end
  endtask

  task automatic test_saturation();
    int lat;
    do_reset();
    for (int f = 1; f <= 5; f++) begin
      pixel(0, 0, 0);
      burst(75, 10, 300, 200);
      burst(360, 330, 120, 200);
      pixel(639, 479, 0);
      wait_result(lat);
      if (f == 1) begin
        checks++; if (s_result_valid !== 1'b1 || s_target_row !== 2'd0 || s_target_col !== 5'd2) begin
          $display("FAIL sat_count got rv=%b %0d,%0d want 1 0,2", s_result_valid, s_target_row, s_target_col); errors++; end
      end
    end
    checks++; if (s_target_row !== 2'd0 || s_target_col !== 5'd2 || s_section_leds !== 18'h00004) begin
      $display("FAIL sat_smooth got %0d,%0d leds=%h want 0,2 00004", s_target_row, s_target_col, s_section_leds); errors++; end
  endtask

  task automatic test_overrun();
    int k;
    do_reset();
    pixel(0, 0, 0);
    burst(182, 170, 200, 200);
    pixel(639, 479, 0);
    k = 1;
    checks++; if (overrun !== 1'b0) begin $display("FAIL ovr_clear got %b want 0", overrun); errors++; end
    repeat (19) begin @(posedge clk); #1; k++; end
    pixel(639, 479, 0);
    k++;
    checks++; if (overrun !== 1'b1) begin $display("FAIL ovr_set got %b want 1", overrun); errors++; end
    while (result_valid !== 1'b1 && k < 400) begin @(posedge clk); #1; k++; end
    checks++; if (k != LAT) begin $display("FAIL ovr_latency got %0d want %0d", k, LAT); errors++; end
    checks++; if (target_row !== 2'd1 || target_col !== 5'd5 || overrun !== 1'b1) begin
      $display("FAIL ovr_result got %0d,%0d ovr=%b want 1,5 1", target_row, target_col, overrun); errors++; end
    repeat (2 * LAT) begin @(posedge clk); #1; end
    checks++; if (busy !== 1'b0) begin $display("FAIL ovr_no_restart got busy=%b want 0", busy); errors++; end
  endtask

  initial begin
    reset = 1'b1;
    vga_ready = 1'b0;
    filtered_video = '0;
    x_count = '0;
    y_count = '0;
    test_reset();
    test_single_hot();
    test_reset_mid_scan();
    test_activation();
    test_clear();
    test_hysteresis();
    test_tie();
    test_frame_end_edge();
    test_saturation();
    test_overrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
